subtract_unit: RTL and testbench
================================

Name: subtract_unit

Overview:
- Registered two's-complement integer subtractor for the ALU datapath: diff = a - b modulo 2^WIDTH, with borrow, overflow, zero and negative status flags.
- Sits beside the adder and logic units in the execute stage. Operands are captured on a valid strobe and the result is presented with a matching valid.
- No backpressure. A new operation may be issued every cycle.

Parameters:
- WIDTH, 32, operand and result width in bits (legal: even, >= 2).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands on a/b are valid this cycle
- a  input  WIDTH  minuend, unsigned or two's complement
- b  input  WIDTH  subtrahend
- out_valid  output  1  diff/flags valid this cycle
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  1 when a < b as unsigned (no carry-out from a + ~b + 1)
- overflow  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]
- zero  output  1  diff == 0
- negative  output  1  diff[MSB]

Behaviour:
- Reset: on a rising clk edge with rst_n=0, all outputs and internal pipeline registers go to 0. Reset takes priority over in_valid. Any in-flight operation is discarded and produces no out_valid.
- Arithmetic: diff = a + (~b) + 1, with carry-in 1 at bit 0. The carry-out of the MSB is cout, and borrow = ~cout. The result wraps modulo 2^WIDTH with no saturation.
- Flags are derived from the same registered result, so they are always consistent with diff.
- Latency (default build): 1 cycle. in_valid=1 at edge N gives out_valid=1 with the result after edge N.
- Throughput: 1 operation per cycle. Back-to-back in_valid produces back-to-back out_valid in issue order.
- in_valid=0: out_valid deasserts on the next edge. diff and flags hold their last value; they are not cleared. Downstream must qualify with out_valid.
- Boundary: a == b gives diff=0, zero=1, borrow=0, overflow=0.
- Boundary: 0 - 1 gives all-ones, borrow=1, negative=1, overflow=0.
- Boundary: most-negative - 1 gives most-positive, overflow=1, borrow=0.
- X-free: outputs never depend on uninitialised state after one reset cycle.

Optional Feature:
- Macro SUBTRACT_PIPE2_EN.
- Defined: two-stage pipeline.
  - Stage 1 computes the low WIDTH/2 bits and registers the low half-result, the inter-half carry, and the upper operand halves.
  - Stage 2 computes the upper half and the flags.
  - Latency 2 cycles, throughput still 1 per cycle.
  - Reset clears both stages and both stage-valid bits.
- Undefined: single-stage, latency 1 as above.
- Results and flags are bit-identical in both builds; only latency differs.

Decomposition:
- Package alu_pkg:
  - default WIDTH constant
  - packed struct alu_flags_t {borrow, overflow, zero, negative}, shared with the adder
  - function computing the flags from (a_msb, b_msb, diff, cout)
- One sub-module, sub_slice: parameterised combinational ripple subtract slice with inputs x, y (width N) and cin, and outputs d (width N) and cout.
  - Single-stage build: one slice at N=WIDTH.
  - SUBTRACT_PIPE2_EN build: two slices at N=WIDTH/2.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, a=5, b=3 -> out_valid=0, diff=0, all flags 0 throughout. First result appears only after rst_n=1.
- Basic and equal operands:
  - a=100, b=58 -> diff=42, all flags 0.
  - a=b=0x1234_5678 -> diff=0, zero=1, borrow=0.
- Wrap and signed cases:
  - a=0, b=1 -> diff=0xFFFF_FFFF, borrow=1, negative=1, overflow=0.
  - a=0x8000_0000, b=1 -> diff=0x7FFF_FFFF, overflow=1, borrow=0.
  - a=0x7FFF_FFFF, b=0xFFFF_FFFF -> diff=0x8000_0000, overflow=1, borrow=1.
- Random streaming: 1024 back-to-back random pairs -> each output equals (a-b) mod 2^32 with matching flags, in order, at exactly the configured latency (1, or 2 with SUBTRACT_PIPE2_EN).
- Gaps and mid-stream reset:
  - in_valid pattern 1,0,1,1,0 -> out_valid shows the same pattern delayed by the latency; diff holds during gaps.
  - Asserting rst_n=0 during streaming -> no out_valid for in-flight operations.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, status-flag bundle and flag derivation.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    // Widest datapath the flag helper accepts; narrower results are zero-extended.
    localparam int unsigned MAX_WIDTH = 128;

    typedef struct packed {
        logic borrow;
        logic overflow;
        logic zero;
        logic negative;
    } alu_flags_t;

    // diff is zero-extended to MAX_WIDTH; width selects the real sign bit.
    function automatic alu_flags_t calc_flags(
        input logic                 a_msb,
        input logic                 b_msb,
        input logic [MAX_WIDTH-1:0] diff,
        input int unsigned          width,
        input logic                 cout
    );
        alu_flags_t f;
        logic       d_msb;
        d_msb      = diff[width-1];
        f.borrow   = ~cout;
        f.overflow = (a_msb != b_msb) && (d_msb != a_msb);
        f.zero     = (diff == '0);
        f.negative = d_msb;
        return f;
    endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational ripple subtract slice: d = x + ~y + cin, with carry-out of the top bit.
module sub_slice #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] d,
    output logic         cout
);

    always_comb begin
        logic [N:0] c;
        logic       yn;
        c    = '0;
        d    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(N); i++) begin
            yn       = ~y[i];
            d[i]     = x[i] ^ yn ^ c[i];
            c[i+1]   = (x[i] & yn) | (c[i] & (x[i] ^ yn));
        end
        cout = c[N];
    end

endmodule

// File: rtl/subtract_unit.sv
// Registered two's-complement subtractor with borrow/overflow/zero/negative flags.
// Build option SUBTRACT_PIPE2_EN splits the carry chain into two pipeline stages (latency 2).
module subtract_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    // Final-stage inputs: whichever stage feeds the output registers.
    logic             fin_valid;
    logic [WIDTH-1:0] fin_diff;
    alu_flags_t       fin_flags;

    logic             valid_q;
    logic [WIDTH-1:0] diff_q;
    alu_flags_t       flags_q;

`ifdef SUBTRACT_PIPE2_EN
    localparam int unsigned HALF = WIDTH / 2;

    logic [HALF-1:0] lo_d;
    logic            lo_cout;
    logic [HALF-1:0] hi_d;
    logic            hi_cout;

    logic            s1_valid_q;
    logic [HALF-1:0] s1_lo_q;
    logic            s1_carry_q;
    logic [HALF-1:0] s1_a_hi_q;
    logic [HALF-1:0] s1_b_hi_q;

    sub_slice #(
        .N (HALF)
    ) u_slice_lo (
        .x    (a[HALF-1:0]),
        .y    (b[HALF-1:0]),
        .cin  (1'b1),
        .d    (lo_d),
        .cout (lo_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_lo_q    <= '0;
            s1_carry_q <= 1'b0;
            s1_a_hi_q  <= '0;
            s1_b_hi_q  <= '0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_lo_q    <= lo_d;
                s1_carry_q <= lo_cout;
                s1_a_hi_q  <= a[WIDTH-1:HALF];
                s1_b_hi_q  <= b[WIDTH-1:HALF];
            end
        end
    end

    sub_slice #(
        .N (HALF)
    ) u_slice_hi (
        .x    (s1_a_hi_q),
        .y    (s1_b_hi_q),
        .cin  (s1_carry_q),
        .d    (hi_d),
        .cout (hi_cout)
    );

    always_comb begin
        fin_valid = s1_valid_q;
        fin_diff  = {hi_d, s1_lo_q};
        fin_flags = calc_flags(s1_a_hi_q[HALF-1], s1_b_hi_q[HALF-1],
                               MAX_WIDTH'(fin_diff), WIDTH, hi_cout);
    end
`else
    logic [WIDTH-1:0] full_d;
    logic             full_cout;

    sub_slice #(
        .N (WIDTH)
    ) u_slice (
        .x    (a),
        .y    (b),
        .cin  (1'b1),
        .d    (full_d),
        .cout (full_cout)
    );

    always_comb begin
        fin_valid = in_valid;
        fin_diff  = full_d;
        fin_flags = calc_flags(a[WIDTH-1], b[WIDTH-1], MAX_WIDTH'(full_d), WIDTH, full_cout);
    end
`endif

    // Result and flags hold across idle cycles; only out_valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            diff_q  <= '0;
            flags_q <= '0;
        end else begin
            valid_q <= fin_valid;
            if (fin_valid) begin
                diff_q  <= fin_diff;
                flags_q <= fin_flags;
            end
        end
    end

    assign out_valid = valid_q;
    assign diff      = diff_q;
    assign borrow    = flags_q.borrow;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;

endmodule

// File: tb/tb_subtract_unit.sv
// Self-checking bench for subtract_unit: directed boundaries, random streaming, gaps, resets.
module tb_subtract_unit;

`ifdef SUBTRACT_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;
    logic        negative;

    int checks;
    int errors;

    // Expected-output model: a delay line of issued results plus the held output value.
    typedef struct {
        logic        v;
        logic [35:0] res;
    } item_t;

    item_t       pipe_q[$];
    logic        exp_valid;
    logic [35:0] exp_res;

    subtract_unit #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {borrow, overflow, zero, negative, diff} from plain integer arithmetic.
    function automatic logic [35:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      sd;
        logic [31:0] d;
        logic        bo;
        logic        ov;
        d  = x - y;
        bo = (x < y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sd = sx - sy;
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return {bo, ov, (d == 32'd0), d[31], d};
    endfunction

    task automatic model_flush();
        item_t e;
        e.v   = 1'b0;
        e.res = '0;
        pipe_q.delete();
        for (int i = 0; i < LAT - 1; i++) pipe_q.push_back(e);
    endtask

    // One clock: drive at negedge, model the edge, compare at the following negedge.
    task automatic cycle(input logic rn, input logic v, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
        item_t e;
        rst_n    = rn;
        in_valid = v;
        a        = x;
        b        = y;
        @(posedge clk);
        if (!rn) begin
            model_flush();
            exp_valid = 1'b0;
            exp_res   = '0;
        end else begin
            e.v   = v;
            e.res = ref_sub(x, y);
            pipe_q.push_back(e);
            e = pipe_q.pop_front();
            exp_valid = e.v;
            if (e.v) exp_res = e.res;
        end
        @(negedge clk);
        check({tag, ".valid"}, 64'(out_valid), 64'(exp_valid));
        check({tag, ".diff"}, 64'(diff), 64'(exp_res[31:0]));
        check({tag, ".flags"}, 64'({borrow, overflow, zero, negative}), 64'(exp_res[35:32]));
    endtask

    initial begin
        logic [31:0] da[6];
        logic [31:0] db[6];
        logic        gap[5];

        checks    = 0;
        errors    = 0;
        exp_valid = 1'b0;
        exp_res   = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        model_flush();
        @(negedge clk);

        // Reset dominates in_valid.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'd5, 32'd3, "reset");
        for (int i = 0; i < LAT + 1; i++) cycle(1'b1, (i == 0), 32'd5, 32'd3, "post_reset");

        da = '{32'd100, 32'h1234_5678, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        db = '{32'd58,  32'h1234_5678, 32'd1, 32'd1,         32'hFFFF_FFFF, 32'h7FFF_FFFF};
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, da[i], db[i], "directed");
        for (int i = 0; i < LAT; i++) cycle(1'b1, 1'b0, 32'd0, 32'd0, "directed_drain");

        for (int i = 0; i < 1024; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom();
            rb = (i % 16 == 0) ? ra : $urandom();
            cycle(1'b1, 1'b1, ra, rb, "stream");
        end
        for (int i = 0; i < LAT; i++) cycle(1'b1, 1'b0, $urandom(), $urandom(), "stream_drain");

        gap = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) cycle(1'b1, gap[i], $urandom(), $urandom(), "gaps");
        end
        for (int i = 0; i < LAT + 1; i++) cycle(1'b1, 1'b0, $urandom(), $urandom(), "gaps_drain");

        // Mid-stream reset drops in-flight operations.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5 + r; i++) cycle(1'b1, 1'b1, $urandom(), $urandom(), "mid_stream");
            cycle(1'b0, 1'b1, $urandom(), $urandom(), "mid_reset");
            for (int i = 0; i < LAT + 1; i++)
                cycle(1'b1, (i == LAT), $urandom(), $urandom(), "after_reset");
        end
        for (int i = 0; i < LAT + 1; i++) cycle(1'b1, 1'b0, 32'd0, 32'd0, "final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
